// File: rtl/video_timing_src.sv
// video_timing_src: clock-enabled raster timing generator with colour bars,
// gradient, checker and memory-backed pixel sources behind a two-stage pipeline.
module video_timing_src #(
    parameter int DATA_W    = 8,
    parameter int CHANNELS  = 3,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_SYNC    = 10,
    parameter int H_BACK    = 10,
    parameter int H_FRONT   = 10,
    parameter int V_SYNC    = 10,
    parameter int V_BACK    = 10,
    parameter int V_FRONT   = 10,
    parameter int CLKEN_DIV = 2,
    parameter int POS_W     = 11,
    localparam int ADDR_W   = $clog2(IMG_HDISP * IMG_VDISP),
    localparam int PIX_W    = DATA_W * CHANNELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              vsync,
    output logic              href,
    output logic              clken,
    output logic [PIX_W-1:0]  data,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int DIV_W = CLKEN_DIV > 1 ? $clog2(CLKEN_DIV) : 1;
    localparam int BAR_W = IMG_HDISP / 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKEN_DIV - 1);
    localparam logic [POS_W-1:0] H_OFF = POS_W'(H_SYNC + H_BACK);
    localparam logic [POS_W-1:0] V_OFF = POS_W'(V_SYNC + V_BACK);
    localparam logic [POS_W-1:0] H_END = POS_W'(H_SYNC + H_BACK + IMG_HDISP);
    localparam logic [POS_W-1:0] V_END = POS_W'(V_SYNC + V_BACK + IMG_VDISP);
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] V_SY = POS_W'(V_SYNC);
    localparam logic [POS_W-1:0] BAR_LAST = POS_W'(7 * BAR_W);
    localparam logic [ADDR_W-1:0] HD_A = ADDR_W'(IMG_HDISP);
    // bar patterns, bar 0 in the low bits; bit k of a pattern drives channel k
    localparam logic [23:0] BARS = {3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state;
    logic [DIV_W-1:0] div;
    logic [POS_W-1:0] hcnt, vcnt, x0, y0, x1, y1;
    logic [1:0] mode_q;
    logic tick, frame_end, origin, active, act1, vs1, tick1;
    logic [2:0] bar;
    logic [CHANNELS+2:0] pat;
    logic [DATA_W-1:0] grad;
    logic [PIX_W-1:0] pixel;

    assign tick = div == DIV_LAST;
    assign frame_end = state != IDLE && tick && hcnt == H_LAST && vcnt == V_LAST;
    assign origin = tick && enable && (state == IDLE || frame_end);
    assign active = state != IDLE && hcnt >= H_OFF && hcnt < H_END && vcnt >= V_OFF && vcnt < V_END;
    assign x0 = active ? hcnt - H_OFF : '0;
    assign y0 = active ? vcnt - V_OFF : '0;

    always_comb begin
        bar = x1 >= BAR_LAST ? 3'd7 : 3'(x1 / POS_W'(BAR_W));
        pat = (CHANNELS + 3)'(BARS[5'(bar) * 5'd3 +: 3]);
        grad = DATA_W'(x1 + y1);
        pixel = '0;
        for (int k = 0; k < CHANNELS; k++)
            pixel[(CHANNELS-1-k)*DATA_W +: DATA_W] = mode_q == 2'd0 ? {DATA_W{pat[k]}} :
                                                      mode_q == 2'd1 ? grad : {DATA_W{x1[3] ^ y1[3]}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            div <= '0;
            hcnt <= '0;
            vcnt <= '0;
            mode_q <= '0;
            frame_cnt <= '0;
            frame_start <= 1'b0;
            mem_addr <= '0;
            x1 <= '0;
            y1 <= '0;
            act1 <= 1'b0;
            vs1 <= 1'b0;
            tick1 <= 1'b0;
            href <= 1'b0;
            clken <= 1'b0;
            vsync <= 1'b0;
            data <= '0;
            x_pos <= '0;
            y_pos <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            frame_start <= origin;
            if (origin) mode_q <= mode;
            if (frame_end) frame_cnt <= frame_cnt + 1'b1;
            if (state == IDLE) begin
                if (origin) state <= RUN;
            end else begin
                if (tick) begin
                    hcnt <= hcnt == H_LAST ? '0 : hcnt + 1'b1;
                    if (hcnt == H_LAST) vcnt <= vcnt == V_LAST ? '0 : vcnt + 1'b1;
                end
                state <= frame_end && !enable ? IDLE : enable ? RUN : FINISH;
            end
            mem_addr <= ADDR_W'(y0) * HD_A + ADDR_W'(x0);
            x1 <= x0;
            y1 <= y0;
            act1 <= active;
            vs1 <= state != IDLE && vcnt >= V_SY;
            tick1 <= tick;
            href <= act1;
            clken <= act1 && tick1;
            vsync <= vs1;
            x_pos <= x1;
            y_pos <= y1;
            data <= !act1 ? '0 : mode_q == 2'd3 ? mem_rdata : pixel;
        end
    end
endmodule

// File: tb/tb_video_timing_src.sv
// tb_video_timing_src: directed pixel table plus reset, enable-drop and
// clock-divider sequences on a 16x4 raster with 2-tick/2-line porches.
module tb_video_timing_src;
    localparam int FRAME = 440;
    localparam int NV = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic [23:0] data;
    logic vsync, href, clken, frame_start;
    logic [10:0] x_pos, y_pos;
    logic [15:0] frame_cnt;

    logic rst1 = 1'b1;
    logic [5:0] mem_addr1;
    logic [23:0] data1;
    logic vsync1, href1, clken1, frame_start1;
    logic [10:0] x_pos1, y_pos1;
    logic [15:0] frame_cnt1;

    int total = 0;
    int bad = 0;
    int runs1 = 0;
    logic [23:0] pix [64];

    typedef struct {
        logic [1:0]  mode;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;
    vec_t tv [NV];

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= 24'(mem_addr);

    video_timing_src #(
        .DATA_W(8), .CHANNELS(3), .IMG_HDISP(16), .IMG_VDISP(4),
        .H_SYNC(2), .H_BACK(2), .H_FRONT(2), .V_SYNC(2), .V_BACK(2), .V_FRONT(2),
        .CLKEN_DIV(2), .POS_W(11)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .vsync(vsync), .href(href), .clken(clken), .data(data),
        .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    video_timing_src #(
        .DATA_W(8), .CHANNELS(3), .IMG_HDISP(16), .IMG_VDISP(4),
        .H_SYNC(2), .H_BACK(2), .H_FRONT(2), .V_SYNC(2), .V_BACK(2), .V_FRONT(2),
        .CLKEN_DIV(1), .POS_W(11)
    ) dut1 (
        .clk(clk), .rst(rst1), .enable(1'b1), .mode(2'd0),
        .mem_addr(mem_addr1), .mem_rdata(24'd0),
        .vsync(vsync1), .href(href1), .clken(clken1), .data(data1),
        .x_pos(x_pos1), .y_pos(y_pos1), .frame_start(frame_start1), .frame_cnt(frame_cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // waits for the next frame origin, then records one full frame of pixels
    task automatic capture(input logic [1:0] m, input int drop_at, input logic [1:0] m2);
        int n = 0;
        int pos_err = 0;
        int dat_err = 0;
        int addr_err = 0;
        int last_nz = 0;
        int wait_c = 0;
        logic [7:0] g;
        logic [23:0] e;
        mode = m;
        for (int i = 0; i < 64; i++) pix[i] = 'x;
        @(negedge clk);
        while (!frame_start && wait_c < 1000) begin
            @(negedge clk);
            wait_c++;
        end
        check("frame_start_seen", 64'(wait_c < 1000), 64'd1);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == drop_at) begin
                enable = 1'b0;
                mode = m2;
            end
            if (mem_addr != 6'd0 && int'(mem_addr) != last_nz) begin
                if (int'(mem_addr) != last_nz + 1) addr_err++;
                last_nz = int'(mem_addr);
            end
            if (clken) begin
                if (int'(x_pos) != n % 16 || int'(y_pos) != n / 16) pos_err++;
                if (x_pos < 16 && y_pos < 4) pix[int'(y_pos) * 16 + int'(x_pos)] = data;
                g = 8'(int'(x_pos) + int'(y_pos));
                e = m == 2'd1 ? {g, g, g} : 24'(int'(y_pos) * 16 + int'(x_pos));
                if ((m == 2'd1 || m == 2'd3) && data !== e) dat_err++;
                n++;
            end
        end
        check("clken_per_frame", 64'(n), 64'd64);
        check("raster_order", 64'(pos_err), 64'd0);
        check("addr_sequence_err", 64'(addr_err), 64'd0);
        check("addr_last", 64'(last_nz), 64'd63);
        check("data_vs_pos_err", 64'(dat_err), 64'd0);
    endtask

    initial begin
        int run = 0;
        int ck = 0;
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        while (runs1 < 8) begin
            @(negedge clk);
            if (href1) begin
                run++;
                ck += int'(clken1);
            end else if (run != 0) begin
                check("div1_href_len", 64'(run), 64'd16);
                check("div1_clken_cnt", 64'(ck), 64'd16);
                runs1++;
                run = 0;
                ck = 0;
            end
        end
    end

    initial begin
        int lat;
        int fs;
        int cur_m;
        tv[0]  = '{2'd0, 0, 0, 24'hFFFFFF};
        tv[1]  = '{2'd0, 1, 3, 24'hFFFFFF};
        tv[2]  = '{2'd0, 2, 0, 24'hFFFF00};
        tv[3]  = '{2'd0, 4, 1, 24'h00FFFF};
        tv[4]  = '{2'd0, 6, 0, 24'h00FF00};
        tv[5]  = '{2'd0, 8, 0, 24'hFF00FF};
        tv[6]  = '{2'd0, 10, 2, 24'hFF0000};
        tv[7]  = '{2'd0, 12, 3, 24'h0000FF};
        tv[8]  = '{2'd0, 14, 0, 24'h000000};
        tv[9]  = '{2'd0, 15, 3, 24'h000000};
        tv[10] = '{2'd1, 3, 2, 24'h050505};
        tv[11] = '{2'd1, 15, 3, 24'h121212};
        tv[12] = '{2'd1, 0, 0, 24'h000000};
        tv[13] = '{2'd2, 7, 0, 24'h000000};
        tv[14] = '{2'd2, 8, 0, 24'hFFFFFF};
        tv[15] = '{2'd2, 15, 2, 24'hFFFFFF};
        tv[16] = '{2'd3, 5, 1, 24'h000015};
        tv[17] = '{2'd3, 15, 3, 24'h00003F};

        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({vsync, href, clken, frame_start, frame_cnt}), 64'd0);
        check("reset_pix", 64'({data, x_pos, y_pos, mem_addr}), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_ctl", 64'({vsync, href, clken, frame_start, frame_cnt}), 64'd0);

        enable = 1'b1;
        lat = 0;
        while (!frame_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_frame_start_lat", 64'(lat >= 1 && lat <= 2), 64'd1);

        cur_m = -1;
        for (int i = 0; i < NV; i++) begin
            if (int'(tv[i].mode) != cur_m) begin
                capture(tv[i].mode, -1, tv[i].mode);
                cur_m = int'(tv[i].mode);
            end
            check($sformatf("mode%0d_px_%0d_%0d", tv[i].mode, tv[i].x, tv[i].y),
                  64'(pix[tv[i].y * 16 + tv[i].x]), 64'(tv[i].exp));
        end

        // enable drop and mode change mid-frame
        rst = 1'b1;
        mode = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        capture(2'd1, 150, 2'd2);
        check("drop_px_3_2", 64'(pix[2 * 16 + 3]), 64'h050505);
        check("drop_px_8_0_mode_held", 64'(pix[8]), 64'h080808);
        repeat (3) @(negedge clk);
        check("drop_frame_cnt", 64'(frame_cnt), 64'd1);
        check("drop_idle_ctl", 64'({vsync, href, clken}), 64'd0);
        fs = 0;
        repeat (100) begin
            @(negedge clk);
            fs += int'(frame_start);
        end
        check("idle_no_frame_start", 64'(fs), 64'd0);
        enable = 1'b1;
        capture(2'd2, -1, 2'd2);
        check("new_mode_px_8_0", 64'(pix[8]), 64'hFFFFFF);
        check("new_mode_px_7_0", 64'(pix[7]), 64'h000000);

        // asynchronous reset in the middle of an active line
        lat = 0;
        while (!href && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        repeat (3) @(negedge clk);
        check("pre_rst_href", 64'(href), 64'd1);
        check("pre_rst_cnt_nonzero", 64'(frame_cnt != 16'd0), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ctl", 64'({vsync, href, clken, frame_start, frame_cnt}), 64'd0);
        check("async_rst_pix", 64'({data, x_pos, y_pos, mem_addr}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        while (!frame_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("restart_frame_start_lat", 64'(lat >= 1 && lat <= 3), 64'd1);
        check("restart_frame_cnt", 64'(frame_cnt), 64'd0);

        check("div1_lines_seen", 64'(runs1), 64'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_src.md
VIDEO_TIMING_SRC -- requirements
Module: video_timing_src

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- DATA_W, 8, bits per colour channel
- CHANNELS, 3, channels per pixel; channel 0 in MSBs
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- H_SYNC / H_BACK / H_FRONT, 10 / 10 / 10, horizontal blanking, in pixel ticks
- V_SYNC / V_BACK / V_FRONT, 10 / 10 / 10, vertical blanking, in lines
- CLKEN_DIV, 2, clk cycles per pixel tick (>=1)
- POS_W, 11, coordinate width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock
- rst, in, 1, asynchronous active-high reset
- enable, in, 1, request frame generation
- mode, in, 2, 0 colour bars, 1 gradient, 2 checker, 3 memory
- mem_addr, out, ceil(log2(IMG_HDISP*IMG_VDISP)), pixel address
- mem_rdata, in, DATA_W*CHANNELS, pixel data; 1-cycle read latency
- vsync, out, 1, low during V_SYNC lines, high otherwise
- href, out, 1, active-pixel qualifier
- clken, out, 1, one-cycle strobe per active pixel
- data, out, DATA_W*CHANNELS, pixel value
- x_pos / y_pos, out, POS_W, coordinates aligned with data
- frame_start, out, 1, one-cycle pulse at frame origin
- frame_cnt, out, 16, completed frames

Function
REQ-003 A divider counter SHALL count 0..CLKEN_DIV-1 in every state; tick SHALL be high in the cycle where it equals CLKEN_DIV-1.
REQ-004 hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1) SHALL advance only on tick while RUN or FINISH; hcnt wraps to 0 and increments vcnt; vcnt wraps to 0 after H_TOTAL-1 of line V_TOTAL-1.
REQ-005 State machine SHALL be IDLE, RUN, FINISH: IDLE->RUN on tick with enable=1 (counters start at 0,0); RUN->FINISH when enable=0; FINISH->RUN when enable=1 again before frame end; RUN or FINISH at the last tick of the frame -> IDLE if enable=0, else remain RUN.
REQ-006 In IDLE counters SHALL hold 0; vsync, href, clken and frame_start SHALL be 0.
REQ-007 mode SHALL be latched on the tick at hcnt=0,vcnt=0; mid-frame mode changes SHALL have no effect until the next frame.
REQ-008 Active region: vcnt in [V_SYNC+V_BACK, +IMG_VDISP) and hcnt in [H_SYNC+H_BACK, +IMG_HDISP); x/y = counter minus offset, 0 outside.
REQ-009 Stage 1 (registered): mem_addr = y*IMG_HDISP + x; 0 outside active.
REQ-010 Stage 2 (registered): href, data, x_pos, y_pos, vsync, i.e. 2 clk cycles after counter update; clken = href AND tick delayed 2 cycles.
REQ-011 Mode 0: 8 bars of width IMG_HDISP/8, the last absorbing any remainder: white, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or 0 (CHANNELS<3: channel k from bit k of the pattern).
REQ-012 Mode 1: every channel = (x+y) mod 2^DATA_W.
REQ-013 Mode 2: all channels all-ones if x[3]^y[3], else 0.
REQ-014 Mode 3: data = mem_rdata captured in stage 2.
REQ-015 Outside active region data, x_pos and y_pos SHALL be 0.
REQ-016 frame_start SHALL pulse one cycle with the tick at hcnt=0,vcnt=0 when entering or continuing RUN.
REQ-017 frame_cnt SHALL increment at each frame end and wrap at 2^16; a frame cut short by reset SHALL NOT count.

Reset
REQ-018 rst high SHALL immediately force IDLE, divider/counters/pipeline to 0, all outputs to 0, frame_cnt to 0, including mid-frame; first frame restarts from 0,0 after release.

Verification
Small config: IMG 16x4, all porches 2, CLKEN_DIV 2, so H_TOTAL 22, V_TOTAL 10, 440 clk/frame.
REQ-019 enable=1, mode 0 -> frame_start after first tick; 64 clken pulses/frame; pixel x=0..1 0xFFFFFF, x=14..15 0x000000.
REQ-020 mode 1 -> data at x=3,y=2 is 0x050505; x_pos/y_pos match data every clken.
REQ-021 mode 3, mem_rdata = address -> mem_addr 0..63 in order; data at (5,1) = 21.
REQ-022 enable dropped mid-frame 1 -> frame completes, frame_cnt=1, IDLE, vsync=0; mode change mid-frame not visible until next frame.
REQ-023 rst pulsed mid-active-line -> all outputs 0 that cycle; restart gives frame_start, frame_cnt=0.
REQ-024 CLKEN_DIV=1 -> clken continuous across each 16-pixel line, href length 16 cycles.
